// File: rtl/pipe_step_ctrl_pkg.sv
// Shared types and widths for the pipeline run/step/halt controller.
package pipe_step_ctrl_pkg;

    localparam int NUM_STAGES = 5;
    localparam int STEP_W     = 8;
    localparam int CYC_W      = 32;

    typedef enum logic [1:0] {
        ST_HALTED = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2,
        ST_DRAIN  = 2'd3
    } state_e;

    // A requested step length of zero still executes one cycle.
    function automatic logic [STEP_W-1:0] step_len(input logic [STEP_W-1:0] n);
        return (n == '0) ? STEP_W'(1) : n;
    endfunction

endpackage

// File: rtl/pipe_step_ctrl_drain_shifter.sv
// Drain stall pattern: fills with 1s from the fetch end (bit 0), one stage per shift; 1-cycle update.
// No backpressure: clear has priority over shift.
module drain_shifter
    import pipe_step_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  shift_i,
    output logic [NUM_STAGES-1:0] fill_o
);

    logic [NUM_STAGES-1:0] fill_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_q <= '0;
        end else if (clr_i) begin
            fill_q <= '0;
        end else if (shift_i) begin
            fill_q <= {fill_q[NUM_STAGES-2:0], 1'b1};
        end
    end

    assign fill_o = fill_q;

endmodule

// File: rtl/pipe_step_ctrl.sv
// Run/step/halt controller driving per-stage stalls of a five-stage pipeline; commands take effect one cycle after sampling.
// No backpressure: commands are single-cycle pulses, ignored in states where they do not apply.
module pipe_step_ctrl
    import pipe_step_ctrl_pkg::*;
#(
    parameter bit RUN_ON_RESET = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_run,
    input  logic              cmd_step,
    input  logic [STEP_W-1:0] step_n,
    input  logic              cmd_halt,
    output logic              s_fe,
    output logic              s_dc,
    output logic              s_ex,
    output logic              s_me,
    output logic              s_wb,
    output logic              halted,
    output logic              busy,
    output logic [CYC_W-1:0]  cyc_cnt
);

    localparam state_e RST_STATE = RUN_ON_RESET ? ST_RUN : ST_HALTED;

    state_e                state_q, state_d;
    logic [STEP_W-1:0]     step_cnt_q, step_cnt_d;
    logic [CYC_W-1:0]      cyc_q;
    logic [NUM_STAGES-1:0] fill;
    logic [NUM_STAGES-1:0] stall_vec;
    logic                  drain_shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RST_STATE;
            step_cnt_q <= '0;
            cyc_q      <= '0;
        end else begin
            state_q    <= state_d;
            step_cnt_q <= step_cnt_d;
            if (!stall_vec[0]) begin
                cyc_q <= cyc_q + CYC_W'(1);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        step_cnt_d = step_cnt_q;
        case (state_q)
            ST_HALTED: begin
                if (cmd_step) begin
                    state_d    = ST_STEP;
                    step_cnt_d = step_len(step_n);
                end else if (cmd_run) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cmd_halt) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_STEP: begin
                if (cmd_halt) begin
                    state_d    = ST_DRAIN;
                    step_cnt_d = '0;
                end else if (cmd_step) begin
                    step_cnt_d = step_len(step_n);
                end else if (step_cnt_q <= STEP_W'(1)) begin
                    // Last stepped cycle: straight to HALTED, no drain.
                    state_d    = ST_HALTED;
                    step_cnt_d = '0;
                end else begin
                    step_cnt_d = step_cnt_q - STEP_W'(1);
                end
            end
            ST_DRAIN: begin
                if (fill[NUM_STAGES-1]) begin
                    state_d = ST_HALTED;
                end
            end
            default: begin
                state_d    = ST_HALTED;
                step_cnt_d = '0;
            end
        endcase
    end

    assign drain_shift = (state_d == ST_DRAIN);

    drain_shifter u_shift (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (!drain_shift),
        .shift_i (drain_shift),
        .fill_o  (fill)
    );

    // Outputs decode only registered state and the shifter register.
    always_comb begin
        halted    = (state_q == ST_HALTED);
        busy      = (state_q == ST_STEP) || (state_q == ST_DRAIN);
        stall_vec = (state_q == ST_DRAIN) ? fill : {NUM_STAGES{halted}};
    end

    assign s_fe    = stall_vec[0];
    assign s_dc    = stall_vec[1];
    assign s_ex    = stall_vec[2];
    assign s_me    = stall_vec[3];
    assign s_wb    = stall_vec[4];
    assign cyc_cnt = cyc_q;

endmodule

// File: tb/tb_pipe_step_ctrl.sv
// Directed bench for pipe_step_ctrl: command-vector table plus drain, async-reset and counter-wrap sequences.
module tb_pipe_step_ctrl;

    logic        clk;
    logic        rst;
    logic        cmd_run, cmd_step, cmd_halt;
    logic [7:0]  step_n;
    logic        s_fe, s_dc, s_ex, s_me, s_wb, halted, busy;
    logic [31:0] cyc_cnt;

    logic        r1_run, r1_step, r1_halt;
    logic [7:0]  r1_n;
    logic        r1_fe, r1_dc, r1_ex, r1_me, r1_wb, r1_halted, r1_busy;
    logic [31:0] r1_cyc;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        run, stp, hlt;
        logic [7:0]  n;
        logic [4:0]  stall;
        logic        ho, bo;
        logic [31:0] cyc;
        logic [7:0]  cnt;
    } vec_t;

    vec_t tbl[$];

    pipe_step_ctrl #(.RUN_ON_RESET(1'b0)) dut (
        .clk(clk), .rst(rst), .cmd_run(cmd_run), .cmd_step(cmd_step), .step_n(step_n),
        .cmd_halt(cmd_halt), .s_fe(s_fe), .s_dc(s_dc), .s_ex(s_ex), .s_me(s_me), .s_wb(s_wb),
        .halted(halted), .busy(busy), .cyc_cnt(cyc_cnt)
    );

    pipe_step_ctrl #(.RUN_ON_RESET(1'b1)) dut1 (
        .clk(clk), .rst(rst), .cmd_run(r1_run), .cmd_step(r1_step), .step_n(r1_n),
        .cmd_halt(r1_halt), .s_fe(r1_fe), .s_dc(r1_dc), .s_ex(r1_ex), .s_me(r1_me), .s_wb(r1_wb),
        .halted(r1_halted), .busy(r1_busy), .cyc_cnt(r1_cyc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, s, h, input logic [7:0] n, input logic [4:0] st,
                       input logic ho, bo, input logic [31:0] c, input logic [7:0] sc);
        vec_t v;
        v.run = r; v.stp = s; v.hlt = h; v.n = n;
        v.stall = st; v.ho = ho; v.bo = bo; v.cyc = c; v.cnt = sc;
        tbl.push_back(v);
    endtask

    // Drive one cycle of commands, then sample 1 time unit after the edge.
    task automatic cycle(input logic r, s, h, input logic [7:0] n);
        cmd_run = r; cmd_step = s; cmd_halt = h; step_n = n;
        @(posedge clk);
        #1;
        cmd_run = 1'b0; cmd_step = 1'b0; cmd_halt = 1'b0; step_n = 8'd0;
    endtask

    function automatic logic [4:0] stalls();
        return {s_wb, s_me, s_ex, s_dc, s_fe};
    endfunction

    task automatic chk_out(input string name, input logic [4:0] st, input logic ho, bo,
                           input logic [31:0] c);
        chk({name, ".stall"}, 32'(stalls()), 32'(st));
        chk({name, ".halted"}, 32'(halted), 32'(ho));
        chk({name, ".busy"}, 32'(busy), 32'(bo));
        chk({name, ".cyc"}, cyc_cnt, c);
    endtask

    initial begin
        cmd_run = 1'b0; cmd_step = 1'b0; cmd_halt = 1'b0; step_n = 8'd0;
        r1_run = 1'b0; r1_step = 1'b0; r1_halt = 1'b0; r1_n = 8'd0;
        rst = 1'b1;

        // Reset values, both parameterisations
        #3;
        chk_out("rst0", 5'h1F, 1'b1, 1'b0, 32'd0);
        chk("rst1.stall", 32'({r1_wb, r1_me, r1_ex, r1_dc, r1_fe}), 32'd0);
        chk("rst1.halted", 32'(r1_halted), 32'd0);
        chk("rst1.busy", 32'(r1_busy), 32'd0);
        chk("rst1.cyc", r1_cyc, 32'd0);

        // Commands while reset is held are ignored
        cmd_run = 1'b1; cmd_step = 1'b1; step_n = 8'd4;
        @(posedge clk);
        #1;
        chk_out("rst_cmd", 5'h1F, 1'b1, 1'b0, 32'd0);
        cmd_run = 1'b0; cmd_step = 1'b0; step_n = 8'd0;
        rst = 1'b0;

        //   run  stp  hlt  n      stall ho   bo   cyc    cnt
        add(1'b0,1'b0,1'b0,8'd0, 5'h1F,1'b1,1'b0,32'd0, 8'd0);
        add(1'b0,1'b1,1'b0,8'd3, 5'h00,1'b0,1'b1,32'd0, 8'd3);
        add(1'b0,1'b0,1'b0,8'd0, 5'h00,1'b0,1'b1,32'd1, 8'd2);
        add(1'b0,1'b0,1'b0,8'd0, 5'h00,1'b0,1'b1,32'd2, 8'd1);
        add(1'b0,1'b0,1'b0,8'd0, 5'h1F,1'b1,1'b0,32'd3, 8'd0);
        add(1'b0,1'b1,1'b0,8'd0, 5'h00,1'b0,1'b1,32'd3, 8'd1);
        add(1'b0,1'b0,1'b0,8'd0, 5'h1F,1'b1,1'b0,32'd4, 8'd0);
        add(1'b0,1'b0,1'b1,8'd0, 5'h1F,1'b1,1'b0,32'd4, 8'd0);
        add(1'b1,1'b1,1'b1,8'd2, 5'h00,1'b0,1'b1,32'd4, 8'd2);
        add(1'b0,1'b1,1'b0,8'd1, 5'h00,1'b0,1'b1,32'd5, 8'd1);
        add(1'b0,1'b0,1'b0,8'd0, 5'h1F,1'b1,1'b0,32'd6, 8'd0);
        add(1'b1,1'b0,1'b0,8'd0, 5'h00,1'b0,1'b0,32'd6, 8'd0);
        add(1'b0,1'b1,1'b0,8'd5, 5'h00,1'b0,1'b0,32'd7, 8'd0);
        add(1'b1,1'b1,1'b1,8'd9, 5'h01,1'b0,1'b1,32'd8, 8'd0);
        add(1'b0,1'b0,1'b0,8'd0, 5'h03,1'b0,1'b1,32'd8, 8'd0);
        add(1'b1,1'b0,1'b0,8'd0, 5'h07,1'b0,1'b1,32'd8, 8'd0);
        add(1'b0,1'b1,1'b0,8'd3, 5'h0F,1'b0,1'b1,32'd8, 8'd0);
        add(1'b0,1'b0,1'b1,8'd0, 5'h1F,1'b0,1'b1,32'd8, 8'd0);
        add(1'b0,1'b0,1'b0,8'd0, 5'h1F,1'b1,1'b0,32'd8, 8'd0);
        add(1'b0,1'b1,1'b0,8'd4, 5'h00,1'b0,1'b1,32'd8, 8'd4);
        add(1'b0,1'b0,1'b0,8'd0, 5'h00,1'b0,1'b1,32'd9, 8'd3);
        add(1'b0,1'b0,1'b1,8'd0, 5'h01,1'b0,1'b1,32'd10,8'd0);
        add(1'b0,1'b0,1'b0,8'd0, 5'h03,1'b0,1'b1,32'd10,8'd0);
        add(1'b0,1'b0,1'b0,8'd0, 5'h07,1'b0,1'b1,32'd10,8'd0);
        add(1'b0,1'b0,1'b0,8'd0, 5'h0F,1'b0,1'b1,32'd10,8'd0);
        add(1'b0,1'b0,1'b0,8'd0, 5'h1F,1'b0,1'b1,32'd10,8'd0);
        add(1'b0,1'b0,1'b0,8'd0, 5'h1F,1'b1,1'b0,32'd10,8'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].run, tbl[i].stp, tbl[i].hlt, tbl[i].n);
            chk_out($sformatf("vec%0d", i), tbl[i].stall, tbl[i].ho, tbl[i].bo, tbl[i].cyc);
            chk($sformatf("vec%0d.step_cnt", i), 32'(dut.step_cnt_q), 32'(tbl[i].cnt));
        end

        // Run for 10 cycles, then halt and watch the ordered drain
        cycle(1'b1, 1'b0, 1'b0, 8'd0);
        chk_out("run_entry", 5'h00, 1'b0, 1'b0, 32'd10);
        repeat (9) cycle(1'b0, 1'b0, 1'b0, 8'd0);
        cycle(1'b0, 1'b0, 1'b1, 8'd0);
        chk_out("drain1", 5'h01, 1'b0, 1'b1, 32'd20);
        for (int k = 2; k <= 5; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 8'd0);
            chk_out($sformatf("drain%0d", k), 5'((1 << k) - 1), 1'b0, 1'b1, 32'd20);
        end
        cycle(1'b0, 1'b0, 1'b0, 8'd0);
        chk_out("drain_done", 5'h1F, 1'b1, 1'b0, 32'd20);

        // Async reset in the middle of drain cycle 3
        cycle(1'b1, 1'b0, 1'b0, 8'd0);
        cycle(1'b0, 1'b0, 1'b0, 8'd0);
        cycle(1'b0, 1'b0, 1'b0, 8'd0);
        chk_out("pre_drain", 5'h00, 1'b0, 1'b0, 32'd22);
        cycle(1'b0, 1'b0, 1'b1, 8'd0);
        cycle(1'b0, 1'b0, 1'b0, 8'd0);
        cycle(1'b0, 1'b0, 1'b0, 8'd0);
        chk_out("mid_drain3", 5'h07, 1'b0, 1'b1, 32'd23);
        #2 rst = 1'b1;
        #1;
        chk_out("async_rst", 5'h1F, 1'b1, 1'b0, 32'd0);
        chk("async_rst.fill", 32'(dut.u_shift.fill_q), 32'd0);
        #1 rst = 1'b0;
        cycle(1'b1, 1'b0, 1'b0, 8'd0);
        chk_out("run_after_rst", 5'h00, 1'b0, 1'b0, 32'd0);

        // Counter wraps from all-ones to zero
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        force dut.cyc_q = 32'hFFFF_FFFE;
        #1 release dut.cyc_q;
        #1;
        chk("wrap_preload", cyc_cnt, 32'hFFFF_FFFE);
        cycle(1'b1, 1'b0, 1'b0, 8'd0);
        chk("wrap_run", cyc_cnt, 32'hFFFF_FFFE);
        cycle(1'b0, 1'b0, 1'b0, 8'd0);
        chk("wrap_c1", cyc_cnt, 32'hFFFF_FFFF);
        cycle(1'b0, 1'b0, 1'b0, 8'd0);
        chk("wrap_c2", cyc_cnt, 32'h0000_0000);
        cycle(1'b0, 1'b0, 1'b0, 8'd0);
        chk("wrap_c3", cyc_cnt, 32'h0000_0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_step_ctrl.md
PIPE_STEP_CTRL -- requirements
Module: pipe_step_ctrl

Interface
REQ-001 Parameter: RUN_ON_RESET, default 0, selects the state entered on reset (0 = HALTED, 1 = RUN).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 cmd_run  input  1  one-cycle pulse; start free-running execution.
REQ-005 cmd_step  input  1  one-cycle pulse; execute step_n cycles, then halt.
REQ-006 step_n  input  8  step length in cycles, sampled with cmd_step; 0 is treated as 1.
REQ-007 cmd_halt  input  1  one-cycle pulse; stop fetch and drain the pipeline in order.
REQ-008 s_fe, s_dc, s_ex, s_me, s_wb  output  1 each  per-stage stall into the five-stage datapath; 1 = stage holds.
REQ-009 halted  output  1  high only in HALTED.
REQ-010 busy  output  1  high in STEP or DRAIN.
REQ-011 cyc_cnt  output  32  count of cycles in which s_fe = 0.

Function
REQ-012 States: HALTED, RUN, STEP, DRAIN.
REQ-013 All outputs are registered: a command sampled at edge N changes the stall outputs for the cycle after edge N.
REQ-014 Per-state stalls: HALTED drives all five stalls to 1; RUN and STEP drive all five to 0.
REQ-015 HALTED -> RUN on cmd_run.
REQ-016 HALTED -> STEP on cmd_step; the remaining-step counter loads max(step_n, 1).
REQ-017 STEP decrements the remaining-step counter each cycle and goes directly to HALTED (all stalls 1 together) after exactly the loaded number of zero-stall cycles.
REQ-018 RUN or STEP -> DRAIN on cmd_halt.
REQ-019 DRAIN stalls stages in pipeline order, one per cycle: s_fe in drain cycle 1, then s_dc in cycle 2, s_ex in cycle 3, s_me in cycle 4, s_wb in cycle 5.
REQ-020 After drain cycle 5, DRAIN -> HALTED.
REQ-021 Once a stall asserts during DRAIN, it stays asserted.
REQ-022 Simultaneous commands: priority is cmd_halt > cmd_step > cmd_run.
REQ-023 Ignored commands: cmd_run in RUN, STEP or DRAIN; cmd_step in RUN or DRAIN; cmd_halt in HALTED or DRAIN.
REQ-024 cmd_step during STEP reloads the remaining-step counter from step_n (0 -> 1).
REQ-025 cyc_cnt increments by 1 in every cycle with s_fe = 0 and wraps 0xFFFFFFFF -> 0 without a flag.
REQ-026 The remaining-step counter never underflows; it holds 0 outside STEP.

Reset
REQ-027 On rst assertion, all state clears immediately, independent of clk: state = HALTED (or RUN if RUN_ON_RESET = 1), cyc_cnt = 0, remaining-step counter = 0, drain progress = 0.
REQ-028 Reset output values: all stalls = 1 and halted = 1 when RUN_ON_RESET = 0; all stalls = 0 and halted = 0 when RUN_ON_RESET = 1; busy = 0 in both cases.
REQ-029 Reset asserted mid-STEP or mid-DRAIN abandons the operation with no partial stall pattern retained.
REQ-030 Commands are ignored while rst is high; the first command sampled is at the first rising edge after rst deasserts.

Structure
REQ-031 Shared pipeline package holds: state enum, NUM_STAGES = 5, STEP_W = 8, CYC_W = 32.
REQ-032 One sub-module, drain_shifter: a 5-bit shift register that fills with 1s from the fetch end, with load-clear and shift-enable inputs.
REQ-033 Stall outputs are taken from the shifter or from the state decode, never from unregistered logic.

Verification
REQ-034 Reset with RUN_ON_RESET = 0, then cmd_step with step_n = 3 -> exactly 3 cycles of all stalls = 0, then all stalls = 1, halted = 1, cyc_cnt = 3.
REQ-035 cmd_run, wait 10 cycles, then cmd_halt -> s_fe = 1 on drain cycle 1, then s_dc, s_ex, s_me, s_wb on successive cycles; halted = 1 after cycle 5; cyc_cnt = 10.
REQ-036 cmd_step with step_n = 0 -> exactly 1 zero-stall cycle.
REQ-037 cmd_run, cmd_step and cmd_halt pulsed in the same cycle while in RUN -> DRAIN entered; step counter unchanged.
REQ-038 rst pulsed between clock edges during drain cycle 3 -> all stalls = 1 and cyc_cnt = 0 immediately; cmd_run on the next edge -> RUN.
REQ-039 cyc_cnt preloaded via force to 0xFFFFFFFE, then 3 RUN cycles -> cyc_cnt reads 0x00000001.
